// File: rtl/error_cam.sv
// error_cam: associative error table holding up to DEPTH (tag, code) pairs.
// Fault detectors write (tag, code) pairs, the readout logic looks them up
// by full tag, and entries can be invalidated individually.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_err   store or update an entry
//   clr_en/clr_addr        invalidate the entry holding clr_addr
//   rd_en/rd_addr          lookup; result on rd_valid/rd_hit/rd_err one cycle later
//   count, full            number of valid entries, count == DEPTH
//   overflow, ovf_clr      sticky "write dropped" flag and its clear
module error_cam #(
   parameter int ADDR_W      = 32,
   parameter int ERR_W       = 10,
   parameter int DEPTH       = 16,
   parameter int ACCUM       = 0,
   parameter int FULL_POLICY = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [ERR_W-1:0]           wr_err,
   input  logic                       clr_en,
   input  logic [ADDR_W-1:0]          clr_addr,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic                       rd_valid,
   output logic                       rd_hit,
   output logic [ERR_W-1:0]           rd_err,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0] VP_LAST_C = IDX_W'(DEPTH-1);

   logic [DEPTH-1:0]  valid_r;
   logic [ADDR_W-1:0] tag_r  [DEPTH];
   logic [ERR_W-1:0]  code_r [DEPTH];
   logic [CNT_W-1:0]  count_r;
   logic              full_r;
   logic [IDX_W-1:0]  vp_r;
   logic              overflow_r;
   logic              rd_valid_r;
   logic              rd_hit_r;
   logic [ERR_W-1:0]  rd_err_r;

   logic              wr_hit_s, clr_hit_s, rd_hit_s, free_found_s;
   logic [IDX_W-1:0]  wr_idx_s, clr_idx_s, rd_idx_s, free_idx_s, wr_slot_s;
   logic [ERR_W-1:0]  rd_code_s, new_code_s;
   logic              same_tag_s;
   logic              do_hit_s, do_fill_s, do_repl_s, do_drop_s, do_clr_s;
   logic              inc_s, dec_s;
   logic [CNT_W-1:0]  count_next_s;

   // Tag match for write, clear and lookup plus lowest free slot; descending scan so the lowest index wins.
   always_comb begin
      wr_hit_s     = 1'b0;
      clr_hit_s    = 1'b0;
      rd_hit_s     = 1'b0;
      free_found_s = 1'b0;
      wr_idx_s     = {IDX_W{1'b0}};
      clr_idx_s    = {IDX_W{1'b0}};
      rd_idx_s     = {IDX_W{1'b0}};
      free_idx_s   = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         wr_idx_s     = (valid_r[i] && (tag_r[i] == wr_addr))  ? IDX_W'(i) : wr_idx_s;
         wr_hit_s     = wr_hit_s  | (valid_r[i] && (tag_r[i] == wr_addr));
         clr_idx_s    = (valid_r[i] && (tag_r[i] == clr_addr)) ? IDX_W'(i) : clr_idx_s;
         clr_hit_s    = clr_hit_s | (valid_r[i] && (tag_r[i] == clr_addr));
         rd_idx_s     = (valid_r[i] && (tag_r[i] == rd_addr))  ? IDX_W'(i) : rd_idx_s;
         rd_hit_s     = rd_hit_s  | (valid_r[i] && (tag_r[i] == rd_addr));
         free_idx_s   = (!valid_r[i]) ? IDX_W'(i) : free_idx_s;
         free_found_s = free_found_s | !valid_r[i];
      end
   end

   // Request decode; free/full decisions use the table state before this edge's clear.
   always_comb begin
      rd_code_s  = code_r[rd_idx_s];
      same_tag_s = wr_en && clr_en && (wr_addr == clr_addr);
      do_hit_s   = wr_en && wr_hit_s;
      do_fill_s  = wr_en && !wr_hit_s && free_found_s;
      do_repl_s  = wr_en && !wr_hit_s && !free_found_s && (FULL_POLICY != 0);
      do_drop_s  = wr_en && !wr_hit_s && !free_found_s && (FULL_POLICY == 0);
      // A same-tag clear is folded into the write: the entry stays put and takes the raw code.
      do_clr_s   = clr_en && clr_hit_s && !same_tag_s;
      if (do_hit_s) begin
         wr_slot_s = wr_idx_s;
      end else if (do_fill_s) begin
         wr_slot_s = free_idx_s;
      end else begin
         wr_slot_s = vp_r;
      end
      if (do_hit_s && (ACCUM != 0) && !same_tag_s) begin
         new_code_s = code_r[wr_idx_s] | wr_err;
      end else begin
         new_code_s = wr_err;
      end
      inc_s = do_fill_s;
      // Replacing the very slot being cleared re-occupies it, so the entry count does not drop.
      dec_s = do_clr_s && !(do_repl_s && (clr_idx_s == vp_r));
      count_next_s = count_r + CNT_W'(inc_s) - CNT_W'(dec_s);
   end

   // Control state: valid bits, occupancy, victim pointer, overflow and the lookup result pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r    <= {DEPTH{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         full_r     <= 1'b0;
         vp_r       <= {IDX_W{1'b0}};
         overflow_r <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_hit_r   <= 1'b0;
         rd_err_r   <= {ERR_W{1'b0}};
      end else begin
         if (do_clr_s) begin
            valid_r[clr_idx_s] <= 1'b0;
         end
         // Placed after the clear so a replacement of the cleared slot leaves it valid.
         if (do_fill_s || do_repl_s) begin
            valid_r[wr_slot_s] <= 1'b1;
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == DEPTH_C);
         if (do_repl_s) begin
            vp_r <= (vp_r == VP_LAST_C) ? {IDX_W{1'b0}} : vp_r + IDX_W'(1'b1);
         end
         if (do_drop_s) begin
            overflow_r <= 1'b1;
         end else if (ovf_clr) begin
            overflow_r <= 1'b0;
         end
         rd_valid_r <= rd_en;
         rd_hit_r   <= rd_en && rd_hit_s;
         rd_err_r   <= (rd_en && rd_hit_s) ? rd_code_s : {ERR_W{1'b0}};
      end
   end

   // Tag and code storage; contents only matter where the valid bit is set, so no reset.
   always_ff @(posedge clk) begin
      if (!rst && (do_hit_s || do_fill_s || do_repl_s)) begin
         tag_r[wr_slot_s]  <= wr_addr;
         code_r[wr_slot_s] <= new_code_s;
      end
   end

   assign rd_valid = rd_valid_r;
   assign rd_hit   = rd_hit_r;
   assign rd_err   = rd_err_r;
   assign count    = count_r;
   assign full     = full_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_error_cam.sv
// Bench for error_cam: two DEPTH=4 instances share one stimulus stream,
// u_a with ACCUM=0/FULL_POLICY=0 and u_b with ACCUM=1/FULL_POLICY=1.
module tb_error_cam;

   localparam logic I = 1'b1;
   localparam logic O = 1'b0;

   logic clk = 1'b0;
   logic rst, wr_en, clr_en, rd_en, ovf_clr;
   logic [31:0] wr_addr, clr_addr, rd_addr;
   logic [9:0]  wr_err;

   logic a_rd_valid, a_rd_hit, a_full, a_overflow;
   logic b_rd_valid, b_rd_hit, b_full, b_overflow;
   logic [9:0] a_rd_err, b_rd_err;
   logic [2:0] a_count, b_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   error_cam #(.ADDR_W(32), .ERR_W(10), .DEPTH(4), .ACCUM(0), .FULL_POLICY(0)) u_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_err(wr_err),
      .clr_en(clr_en), .clr_addr(clr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(a_rd_valid), .rd_hit(a_rd_hit), .rd_err(a_rd_err), .count(a_count),
      .full(a_full), .overflow(a_overflow), .ovf_clr(ovf_clr));

   error_cam #(.ADDR_W(32), .ERR_W(10), .DEPTH(4), .ACCUM(1), .FULL_POLICY(1)) u_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_err(wr_err),
      .clr_en(clr_en), .clr_addr(clr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(b_rd_valid), .rd_hit(b_rd_hit), .rd_err(b_rd_err), .count(b_count),
      .full(b_full), .overflow(b_overflow), .ovf_clr(ovf_clr));

   // ---------------- reference model: slot table per instance ----------------
   logic        m_valid [2][4];
   logic [31:0] m_tag   [2][4];
   logic [9:0]  m_code  [2][4];
   int          m_vp    [2];
   logic        m_ovf   [2];
   logic        m_rv    [2];
   logic        m_rh    [2];
   logic [9:0]  m_re    [2];

   function automatic int mfind(int k, logic [31:0] t);
      for (int i = 0; i < 4; i++)
         if (m_valid[k][i] && m_tag[k][i] == t) return i;
      return -1;
   endfunction

   function automatic int mcount(int k);
      int n = 0;
      for (int i = 0; i < 4; i++) n += m_valid[k][i] ? 1 : 0;
      return n;
   endfunction

   task automatic model_step(int k);
      bit acc = (k == 1);
      bit fp  = (k == 1);
      int ri, wh, ch, fr;
      bit same;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_valid[k][i] = 1'b0;
         m_vp[k] = 0; m_ovf[k] = 1'b0;
         m_rv[k] = 1'b0; m_rh[k] = 1'b0; m_re[k] = 10'h000;
         return;
      end
      ri = mfind(k, rd_addr);
      m_rv[k] = rd_en;
      m_rh[k] = rd_en && (ri >= 0);
      m_re[k] = m_rh[k] ? m_code[k][ri] : 10'h000;
      wh   = mfind(k, wr_addr);
      ch   = mfind(k, clr_addr);
      same = wr_en && clr_en && (wr_addr == clr_addr);
      fr   = -1;
      for (int i = 3; i >= 0; i--) if (!m_valid[k][i]) fr = i;
      if (ovf_clr) m_ovf[k] = 1'b0;
      if (clr_en && ch >= 0 && !same) m_valid[k][ch] = 1'b0;
      if (wr_en) begin
         if (wh >= 0) begin
            m_code[k][wh] = (acc && !same) ? (m_code[k][wh] | wr_err) : wr_err;
         end else if (fr >= 0) begin
            m_valid[k][fr] = 1'b1; m_tag[k][fr] = wr_addr; m_code[k][fr] = wr_err;
         end else if (fp) begin
            m_valid[k][m_vp[k]] = 1'b1; m_tag[k][m_vp[k]] = wr_addr; m_code[k][m_vp[k]] = wr_err;
            m_vp[k] = (m_vp[k] + 1) % 4;
         end else begin
            m_ovf[k] = 1'b1;
         end
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic mcheck(int k);
      string p = (k == 0) ? "a" : "b";
      chk({p, ".rd_valid"}, (k == 0) ? a_rd_valid : b_rd_valid, m_rv[k]);
      chk({p, ".rd_hit"},   (k == 0) ? a_rd_hit   : b_rd_hit,   m_rh[k]);
      chk({p, ".rd_err"},   (k == 0) ? a_rd_err   : b_rd_err,   m_re[k]);
      chk({p, ".count"},    (k == 0) ? a_count    : b_count,    mcount(k));
      chk({p, ".full"},     (k == 0) ? a_full     : b_full,     mcount(k) == 4);
      chk({p, ".overflow"}, (k == 0) ? a_overflow : b_overflow, m_ovf[k]);
   endtask

   // One clock: drive, advance model, sample 1 time unit after the edge, compare.
   task automatic step(input logic r, input logic w, input logic [31:0] wa, input logic [9:0] we,
                       input logic c, input logic [31:0] ca, input logic rd, input logic [31:0] ra,
                       input logic oc);
      rst = r; wr_en = w; wr_addr = wa; wr_err = we;
      clr_en = c; clr_addr = ca; rd_en = rd; rd_addr = ra; ovf_clr = oc;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      mcheck(0);
      mcheck(1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic r, w; logic [31:0] wa; logic [9:0] we; logic c; logic [31:0] ca;
      logic rd; logic [31:0] ra; logic oc;
      logic rv, ah; logic [9:0] ae; logic [2:0] ac; logic af, ao;
      logic bh; logic [9:0] be; logic [2:0] bc;
   } vec_t;

   function automatic vec_t mk(logic r, logic w, logic [31:0] wa, logic [9:0] we, logic c,
                               logic [31:0] ca, logic rd, logic [31:0] ra, logic oc,
                               logic rv, logic ah, logic [9:0] ae, logic [2:0] ac, logic af,
                               logic ao, logic bh, logic [9:0] be, logic [2:0] bc);
      vec_t v;
      v.r = r; v.w = w; v.wa = wa; v.we = we; v.c = c; v.ca = ca; v.rd = rd; v.ra = ra;
      v.oc = oc; v.rv = rv; v.ah = ah; v.ae = ae; v.ac = ac; v.af = af; v.ao = ao;
      v.bh = bh; v.be = be; v.bc = bc;
      return v;
   endfunction

   vec_t        tbl [32];
   logic [31:0] pool [8];

   initial begin
      //               r  w  wa            we      c  ca     rd ra            oc | rv ah ae      ac    af ao | bh be      bc
      tbl[0]  = mk(I, O, 32'h0,        10'h000, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd0, O, O,  O, 10'h000, 3'd0);
      tbl[1]  = mk(O, I, 32'hAABBCCDD, 10'h2AA, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd1, O, O,  O, 10'h000, 3'd1);
      tbl[2]  = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'hAABBCCDD, O,  I, I, 10'h2AA, 3'd1, O, O,  I, 10'h2AA, 3'd1);
      tbl[3]  = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'hDEADBEEF, O,  I, O, 10'h000, 3'd1, O, O,  O, 10'h000, 3'd1);
      tbl[4]  = mk(O, I, 32'h12345678, 10'h38E, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd2, O, O,  O, 10'h000, 3'd2);
      tbl[5]  = mk(O, I, 32'h12345678, 10'h071, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd2, O, O,  O, 10'h000, 3'd2);
      tbl[6]  = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h12345678, O,  I, I, 10'h071, 3'd2, O, O,  I, 10'h3FF, 3'd2);
      tbl[7]  = mk(I, O, 32'h0,        10'h000, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd0, O, O,  O, 10'h000, 3'd0);
      tbl[8]  = mk(O, I, 32'h1,        10'h011, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd1, O, O,  O, 10'h000, 3'd1);
      tbl[9]  = mk(O, I, 32'h2,        10'h012, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd2, O, O,  O, 10'h000, 3'd2);
      tbl[10] = mk(O, I, 32'h3,        10'h013, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd3, O, O,  O, 10'h000, 3'd3);
      tbl[11] = mk(O, I, 32'h4,        10'h014, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[12] = mk(O, I, 32'h5,        10'h015, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, I,  O, 10'h000, 3'd4);
      tbl[13] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h5,        O,  I, O, 10'h000, 3'd4, I, I,  I, 10'h015, 3'd4);
      tbl[14] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h1,        O,  I, I, 10'h011, 3'd4, I, I,  O, 10'h000, 3'd4);
      tbl[15] = mk(O, O, 32'h0,        10'h000, O, 32'h0, O, 32'h0,        I,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[16] = mk(O, I, 32'h6,        10'h016, O, 32'h0, O, 32'h0,        I,  O, O, 10'h000, 3'd4, I, I,  O, 10'h000, 3'd4);
      tbl[17] = mk(O, O, 32'h0,        10'h000, O, 32'h0, O, 32'h0,        I,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[18] = mk(O, O, 32'h0,        10'h000, I, 32'h2, I, 32'h2,        O,  I, I, 10'h012, 3'd3, O, O,  O, 10'h000, 3'd4);
      tbl[19] = mk(O, I, 32'h9,        10'h019, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[20] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h9,        O,  I, I, 10'h019, 3'd4, I, O,  I, 10'h019, 3'd4);
      tbl[21] = mk(O, O, 32'h0,        10'h000, I, 32'h3, O, 32'h0,        O,  O, O, 10'h000, 3'd3, O, O,  O, 10'h000, 3'd4);
      tbl[22] = mk(O, I, 32'h7,        10'h001, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[23] = mk(O, I, 32'h7,        10'h3FE, I, 32'h7, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, O,  O, 10'h000, 3'd4);
      tbl[24] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h7,        O,  I, I, 10'h3FE, 3'd4, I, O,  I, 10'h3FE, 3'd4);
      tbl[25] = mk(O, I, 32'hA,        10'h00A, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd4, I, I,  O, 10'h000, 3'd4);
      tbl[26] = mk(I, I, 32'h55,       10'h001, O, 32'h0, I, 32'h1,        O,  O, O, 10'h000, 3'd0, O, O,  O, 10'h000, 3'd0);
      tbl[27] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h1,        O,  I, O, 10'h000, 3'd0, O, O,  O, 10'h000, 3'd0);
      tbl[28] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h9,        O,  I, O, 10'h000, 3'd0, O, O,  O, 10'h000, 3'd0);
      tbl[29] = mk(O, I, 32'h100,      10'h000, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd1, O, O,  O, 10'h000, 3'd1);
      tbl[30] = mk(O, O, 32'h0,        10'h000, O, 32'h0, I, 32'h100,      O,  I, I, 10'h000, 3'd1, O, O,  I, 10'h000, 3'd1);
      tbl[31] = mk(O, O, 32'h0,        10'h000, O, 32'h0, O, 32'h0,        O,  O, O, 10'h000, 3'd1, O, O,  O, 10'h000, 3'd1);

      for (int k = 0; k < 2; k++) begin
         m_vp[k] = 0; m_ovf[k] = 1'b0; m_rv[k] = 1'b0; m_rh[k] = 1'b0; m_re[k] = 10'h000;
         for (int i = 0; i < 4; i++) begin
            m_valid[k][i] = 1'b0; m_tag[k][i] = 32'h0; m_code[k][i] = 10'h000;
         end
      end

      for (int n = 0; n < 32; n++) begin
         step(tbl[n].r, tbl[n].w, tbl[n].wa, tbl[n].we, tbl[n].c, tbl[n].ca,
              tbl[n].rd, tbl[n].ra, tbl[n].oc);
         chk($sformatf("tbl%0d.a.rd_valid", n), a_rd_valid, tbl[n].rv);
         chk($sformatf("tbl%0d.a.rd_hit", n),   a_rd_hit,   tbl[n].ah);
         chk($sformatf("tbl%0d.a.rd_err", n),   a_rd_err,   tbl[n].ae);
         chk($sformatf("tbl%0d.a.count", n),    a_count,    tbl[n].ac);
         chk($sformatf("tbl%0d.a.full", n),     a_full,     tbl[n].af);
         chk($sformatf("tbl%0d.a.overflow", n), a_overflow, tbl[n].ao);
         chk($sformatf("tbl%0d.b.rd_valid", n), b_rd_valid, tbl[n].rv);
         chk($sformatf("tbl%0d.b.rd_hit", n),   b_rd_hit,   tbl[n].bh);
         chk($sformatf("tbl%0d.b.rd_err", n),   b_rd_err,   tbl[n].be);
         chk($sformatf("tbl%0d.b.count", n),    b_count,    tbl[n].bc);
      end

      // Randomised traffic over a small tag pool; two pairs differ only in one bit.
      for (int i = 0; i < 6; i++) pool[i] = $urandom;
      pool[6] = pool[0] ^ 32'h8000_0000;
      pool[7] = pool[1] ^ 32'h0000_0001;
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 79) == 0,
              $urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], 10'($urandom),
              $urandom_range(0, 9) < 3, pool[$urandom_range(0, 7)],
              $urandom_range(0, 9) < 6, pool[$urandom_range(0, 7)],
              $urandom_range(0, 9) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
